// File: rtl/lsu_mem_master_if.sv
// Request/response and data-memory bus for the MEM-stage load/store initiator.
interface lsu_mem_master_if #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
);
  logic                  req_valid;
  logic                  req_we;
  logic [31:0]           req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [2:0]            req_funct3;
  logic                  busy;
  logic                  done;
  logic [DATA_W-1:0]     load_data;
  logic                  err;
  logic                  MemRead;
  logic                  MemWrite;
  logic [DM_ADDRESS-1:0] a;
  logic [DATA_W-1:0]     wd;
  logic [2:0]            Funct3;
  logic [DATA_W-1:0]     rd;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata, req_funct3, rd,
    output busy, done, load_data, err, MemRead, MemWrite, a, wd, Funct3
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata, req_funct3, rd,
    input  busy, done, load_data, err, MemRead, MemWrite, a, wd, Funct3
  );
endinterface

// File: rtl/lsu_mem_master.sv
// MEM-stage load/store initiator: word-aligned memory accesses, sub-word load
// extraction and read-modify-write sub-word stores.
module lsu_mem_master #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input logic               clk,
  input logic               rst_n,
  lsu_mem_master_if.master  bus
);

  typedef enum logic [2:0] {IDLE, RD, WR, DONE, ERR} state_t;

  state_t            state;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic [15:0]       wdata_q;
  logic              legal;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [DATA_W-1:0] ext_word;
  logic [DATA_W-1:0] lane_mask;
  logic [DATA_W-1:0] lane_ins;
  logic [DATA_W-1:0] merged_word;

  assign bus.Funct3 = 3'b010;
  assign bus.busy   = (state != IDLE) || bus.req_valid;

  always_comb begin
    legal = 1'b0;
    case (bus.req_funct3)
      3'b000:  legal = 1'b1;
      3'b001:  legal = ~bus.req_addr[0];
      3'b010:  legal = (bus.req_addr[1:0] == 2'b00);
      3'b100:  legal = ~bus.req_we;
      3'b101:  legal = ~bus.req_we & ~bus.req_addr[0];
      default: legal = 1'b0;
    endcase
    if (bus.req_addr[31:DM_ADDRESS] != '0) legal = 1'b0;
  end

  always_comb begin
    byte_sel = 8'(bus.rd >> {off_q, 3'b000});
    half_sel = 16'(bus.rd >> {off_q[1], 4'b0000});
    case (f3_q)
      3'b000:  ext_word = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      3'b001:  ext_word = {{(DATA_W-16){half_sel[15]}}, half_sel};
      3'b100:  ext_word = {{(DATA_W-8){1'b0}}, byte_sel};
      3'b101:  ext_word = {{(DATA_W-16){1'b0}}, half_sel};
      default: ext_word = bus.rd;
    endcase
  end

  // Only SB (f3 000) and SH (f3 001) reach the merge path.
  always_comb begin
    if (f3_q[0]) begin
      lane_mask = DATA_W'(16'hFFFF) << {off_q[1], 4'b0000};
      lane_ins  = DATA_W'(wdata_q) << {off_q[1], 4'b0000};
    end else begin
      lane_mask = DATA_W'(8'hFF) << {off_q, 3'b000};
      lane_ins  = DATA_W'(wdata_q[7:0]) << {off_q, 3'b000};
    end
    merged_word = (bus.rd & ~lane_mask) | lane_ins;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      we_q          <= 1'b0;
      f3_q          <= '0;
      off_q         <= '0;
      wdata_q       <= '0;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
      bus.MemRead   <= 1'b0;
      bus.MemWrite  <= 1'b0;
      bus.load_data <= '0;
      bus.a         <= '0;
      bus.wd        <= '0;
    end else begin
      bus.done     <= 1'b0;
      bus.err      <= 1'b0;
      bus.MemRead  <= 1'b0;
      bus.MemWrite <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            we_q    <= bus.req_we;
            f3_q    <= bus.req_funct3;
            off_q   <= bus.req_addr[1:0];
            wdata_q <= bus.req_wdata[15:0];
            if (!legal) begin
              state    <= ERR;
              bus.done <= 1'b1;
              bus.err  <= 1'b1;
            end else if (bus.req_we && bus.req_funct3 == 3'b010) begin
              state        <= WR;
              bus.MemWrite <= 1'b1;
              bus.a        <= {bus.req_addr[DM_ADDRESS-1:2], 2'b00};
              bus.wd       <= bus.req_wdata;
            end else begin
              state       <= RD;
              bus.MemRead <= 1'b1;
              bus.a       <= {bus.req_addr[DM_ADDRESS-1:2], 2'b00};
            end
          end
        end
        RD: begin
          if (!we_q) begin
            bus.load_data <= ext_word;
            bus.done      <= 1'b1;
            state         <= DONE;
          end else begin
            bus.wd       <= merged_word;
            bus.MemWrite <= 1'b1;
            state        <= WR;
          end
        end
        WR: begin
          bus.done <= 1'b1;
          state    <= DONE;
        end
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master with a word-array data memory model.
module tb_lsu_mem_master;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_mem_master_if #(.DM_ADDRESS(9), .DATA_W(32)) bus ();
  lsu_mem_master #(.DM_ADDRESS(9), .DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] mem [0:127];
  assign bus.rd = mem[bus.a[8:2]];
  always @(posedge clk) if (bus.MemWrite) mem[bus.a[8:2]] <= bus.wd;

  int total = 0;
  int bad = 0;

  int          lat;
  logic        saw_rd, saw_wr, both, busy_ok, busy_acc, err_o, err_stray, done_seen;
  logic [8:0]  wr_a;
  logic [31:0] wr_d, ld;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue at an IDLE negedge, follow until done (bounded), return at the next IDLE negedge.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] f3);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr;
    bus.req_wdata = wdata; bus.req_funct3 = f3;
    #1 busy_acc = bus.busy;
    lat = 0; saw_rd = 0; saw_wr = 0; both = 0; busy_ok = 1; err_o = 0;
    err_stray = 0; done_seen = 0; wr_a = '0; wr_d = '0; ld = '0;
    while (!done_seen && lat < 10) begin
      @(negedge clk);
      lat++;
      if (bus.MemRead) saw_rd = 1;
      if (bus.MemWrite) begin saw_wr = 1; wr_a = bus.a; wr_d = bus.wd; end
      if (bus.MemRead && bus.MemWrite) both = 1;
      if (!bus.busy) busy_ok = 0;
      if (bus.done) begin done_seen = 1; err_o = bus.err; ld = bus.load_data; end
      else if (bus.err) err_stray = 1;
      bus.req_valid = 1'b0;
    end
    chk("done_seen", 32'(done_seen), 32'd1);
    @(negedge clk);
  endtask

  task automatic load_chk(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] exp);
    do_req(1'b0, addr, 32'h0, f3);
    chk({tag, "_lat"}, 32'(lat), 32'd2);
    chk({tag, "_data"}, ld, exp);
    chk({tag, "_err"}, 32'(err_o), 32'd0);
    chk({tag, "_nowr"}, 32'(saw_wr), 32'd0);
  endtask

  task automatic store_chk(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [2:0] f3, input int exp_lat, input logic [31:0] exp_wd);
    do_req(1'b1, addr, wdata, f3);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_a"}, 32'(wr_a), {23'd0, addr[8:2], 2'b00});
    chk({tag, "_wd"}, wr_d, exp_wd);
    chk({tag, "_rd"}, 32'(saw_rd), (exp_lat == 3) ? 32'd1 : 32'd0);
    chk({tag, "_err"}, 32'(err_o), 32'd0);
    chk({tag, "_excl"}, 32'(both), 32'd0);
  endtask

  task automatic err_chk(input string tag, input logic we, input logic [31:0] addr,
                         input logic [2:0] f3);
    do_req(we, addr, 32'h12345678, f3);
    chk({tag, "_lat"}, 32'(lat), 32'd1);
    chk({tag, "_err"}, 32'(err_o), 32'd1);
    chk({tag, "_strobes"}, {30'd0, saw_rd, saw_wr}, 32'd0);
  endtask

  initial begin
    bus.req_valid = 0; bus.req_we = 0; bus.req_addr = '0; bus.req_wdata = '0; bus.req_funct3 = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done_err", {30'd0, bus.done, bus.err}, 32'd0);
    chk("rst_strobes", {30'd0, bus.MemRead, bus.MemWrite}, 32'd0);
    chk("rst_a", 32'(bus.a), 32'd0);
    chk("rst_wd", bus.wd, 32'd0);
    chk("rst_ld", bus.load_data, 32'd0);
    chk("funct3", 32'(bus.Funct3), 32'd2);
    rst_n = 1'b1;
    @(negedge clk);

    store_chk("sw10", 32'h10, 32'hDEADBEEF, 3'b010, 2, 32'hDEADBEEF);
    chk("sw10_busy_acc", 32'(busy_acc), 32'd1);
    chk("sw10_busy", 32'(busy_ok), 32'd1);
    load_chk("lw10", 32'h10, 3'b010, 32'hDEADBEEF);

    store_chk("sw20", 32'h20, 32'h80FF7F01, 3'b010, 2, 32'h80FF7F01);
    load_chk("lb23", 32'h23, 3'b000, 32'hFFFFFF80);
    load_chk("lbu23", 32'h23, 3'b100, 32'h00000080);
    load_chk("lh22", 32'h22, 3'b001, 32'hFFFF80FF);
    load_chk("lhu20", 32'h20, 3'b101, 32'h00007F01);
    load_chk("lb20", 32'h20, 3'b000, 32'h00000001);

    store_chk("sw20b", 32'h20, 32'h11223344, 3'b010, 2, 32'h11223344);
    store_chk("sb21", 32'h21, 32'h000000AA, 3'b000, 3, 32'h1122AA44);
    store_chk("sh22", 32'h22, 32'h0000BEEF, 3'b001, 3, 32'hBEEFAA44);
    chk("mem20", mem[8], 32'hBEEFAA44);
    load_chk("lw20", 32'h20, 3'b010, 32'hBEEFAA44);

    store_chk("sw1fc", 32'h1FC, 32'h0BADF00D, 3'b010, 2, 32'h0BADF00D);
    load_chk("lw1fc", 32'h1FC, 3'b010, 32'h0BADF00D);

    err_chk("lw22", 1'b0, 32'h22, 3'b010);
    err_chk("sh21", 1'b1, 32'h21, 3'b001);
    err_chk("lw400", 1'b0, 32'h400, 3'b010);
    err_chk("ld_f3_011", 1'b0, 32'h10, 3'b011);
    err_chk("st_f3_100", 1'b1, 32'h10, 3'b100);
    chk("mem10_kept", mem[4], 32'hDEADBEEF);

    // Back-to-back SW then LW with req_valid held high throughout.
    bus.req_valid = 1; bus.req_we = 1; bus.req_addr = 32'h40;
    bus.req_wdata = 32'h12345678; bus.req_funct3 = 3'b010;
    #1 chk("b2b_busy0", 32'(bus.busy), 32'd1);
    @(negedge clk);
    chk("b2b_c1_wr", {30'd0, bus.MemWrite, bus.busy}, 32'd3);
    chk("b2b_c1_a", 32'(bus.a), 32'h40);
    @(negedge clk);
    chk("b2b_c2_done", {30'd0, bus.done, bus.busy}, 32'd3);
    bus.req_we = 0; bus.req_wdata = '0;
    @(negedge clk);
    chk("b2b_c3_idle", {29'd0, bus.done, bus.MemRead, bus.busy}, 32'd1);
    @(negedge clk);
    chk("b2b_c4_rd", {30'd0, bus.MemRead, bus.busy}, 32'd3);
    @(negedge clk);
    chk("b2b_c5_done", {30'd0, bus.done, bus.busy}, 32'd3);
    chk("b2b_data", bus.load_data, 32'h12345678);
    bus.req_valid = 0;
    @(negedge clk);
    chk("b2b_c6_idle", 32'(bus.busy), 32'd0);

    // Reset during the WR cycle of an SB must abandon the write.
    store_chk("sw30", 32'h30, 32'hCAFEF00D, 3'b010, 2, 32'hCAFEF00D);
    bus.req_valid = 1; bus.req_we = 1; bus.req_addr = 32'h30;
    bus.req_wdata = 32'h55; bus.req_funct3 = 3'b000;
    @(negedge clk);
    bus.req_valid = 0;
    @(negedge clk);
    chk("rstmid_inwr", 32'(bus.MemWrite), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rstmid_strobes", {28'd0, bus.MemRead, bus.MemWrite, bus.done, bus.err}, 32'd0);
    chk("rstmid_busy", 32'(bus.busy), 32'd0);
    chk("rstmid_a", 32'(bus.a), 32'd0);
    chk("rstmid_wd", bus.wd, 32'd0);
    chk("rstmid_ld", bus.load_data, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("rstmid_mem", mem[12], 32'hCAFEF00D);
    chk("rstmid_after", {29'd0, bus.MemWrite, bus.done, bus.busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store initiator for the MEM stage: takes one load or store request from the pipeline and drives the data memory's word-granular MemRead/MemWrite/address/write-data/Funct3 interface.
- Aligns the access to a word boundary and extracts, sign- or zero-extends loaded bytes/halfwords by byte offset.
- Builds sub-word stores (SB/SH) as a read-modify-write of the containing word.
- Raises a busy/stall indication while a request is in flight, and flags misaligned or out-of-range requests without touching memory.

Parameters:
- DM_ADDRESS, 9, width of the data memory address port (byte address).
- DATA_W, 32, data width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  pipeline presents a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address (ALU result).
- req_wdata  input  DATA_W  store data (rs2).
- req_funct3  input  3  instruction bits 14:12.
- busy  output  1  high while a request is in flight; pipeline must hold the request and stall.
- done  output  1  one-cycle pulse when the request completes, with or without error.
- load_data  output  DATA_W  extended load result; valid when done and the request was a load.
- err  output  1  one-cycle pulse, coincident with done, on a misaligned, out-of-range or illegal-funct3 request.
- MemRead  output  1  to data memory.
- MemWrite  output  1  to data memory.
- a  output  DM_ADDRESS  word-aligned byte address to memory; a[1:0] always 0.
- wd  output  DATA_W  write word to memory.
- Funct3  output  3  to memory; always 3'b010, since every access is a full word.
- rd  input  DATA_W  read word from memory, combinational on a.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State = IDLE.
  - busy, done, err, MemRead, MemWrite = 0.
  - load_data, a, wd = 0.
  - Reset mid-operation abandons the request; no write is issued after reset deasserts.
- Accept rule:
  - A request is accepted when req_valid=1 and the state is IDLE.
  - On acceptance, addr, we, wdata and funct3 are registered.
  - busy is combinational: high when the state is not IDLE, or when req_valid=1 while in IDLE. The pipeline therefore stalls from the acceptance cycle onward.
- Legality, checked at acceptance:
  - Loads allow funct3 000 (LB), 001 (LH), 010 (LW), 100 (LBU), 101 (LHU).
  - Stores allow funct3 000 (SB), 001 (SH), 010 (SW).
  - LH/LHU/SH require addr[0]=0; LW/SW require addr[1:0]=0.
  - addr[31:DM_ADDRESS] must be 0.
  - Any violation -> ERR.
- States:
  - IDLE -> RD (load or SB/SH) | WR (SW) | ERR.
  - RD: MemRead=1, a={addr[DM_ADDRESS-1:2],2'b00}; rd is captured at the clock edge.
    - Load -> DONE; load_data is registered from the captured word.
    - SB/SH -> WR; the merged word is registered.
  - WR: MemWrite=1, a as in RD, wd = merged word (SB/SH) or wdata (SW). -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
  - ERR: done=1, err=1 for one cycle, no memory strobe -> IDLE.
- Latency from acceptance edge to done:
  - Load: 2 cycles.
  - SW: 2 cycles.
  - SB/SH: 3 cycles.
  - Error: 1 cycle.
- Load extraction, with offset o=addr[1:0] (little-endian):
  - Byte = word[8o+7:8o]; halfword = word[16*o[1]+15:16*o[1]].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Store merge:
  - SB replaces byte lane o with wdata[7:0].
  - SH replaces halfword lane o[1] with wdata[15:0].
  - All other lanes keep the value read in RD.
- MemRead and MemWrite are never high in the same cycle.
- Both strobes are 0 in IDLE, DONE and ERR.
- req_valid during a non-IDLE state is ignored; the pipeline holds it while busy.
- A new request may be accepted in the cycle after DONE (back-to-back, no bubble beyond DONE).

Test Plan:
- Reset: assert rst_n=0 mid-WR of an SB -> all outputs 0 immediately; memory word unchanged after release.
- SW addr=0x10, wdata=0xDEADBEEF -> WR cycle with a=0x10, wd=0xDEADBEEF, MemWrite=1; done 2 cycles after acceptance. Then LW 0x10 -> load_data=0xDEADBEEF.
- Word 0x80FF7F01 at 0x20:
  - LB 0x23 -> 0xFFFFFF80.
  - LBU 0x23 -> 0x00000080.
  - LH 0x22 -> 0xFFFF80FF.
  - LHU 0x20 -> 0x00007F01.
  - LB 0x20 -> 0x00000001.
- SB addr=0x21, wdata=0x000000AA onto word 0x11223344 -> RD then WR with wd=0x1122AA44; done 3 cycles after acceptance. SH 0x22 wdata=0xBEEF -> 0xBEEFAA44.
- LW 0x22, SH 0x21, and LW 0x400 -> err and done pulse 1 cycle after acceptance; MemRead/MemWrite never asserted.
- Back-to-back SW then LW with req_valid held high -> busy covers both requests; one idle-to-accept cycle after the first DONE; the second result is correct.
